// File: rtl/imem_pkg.sv
// Shared constants, default parameters and response payload type for the
// instruction-memory responder.
package imem_pkg;

  localparam int unsigned DEFAULT_MEM_WORDS  = 1024;
  localparam int unsigned DEFAULT_LATENCY    = 2;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam int unsigned WORD_W             = 32;

  // Returned for fetches outside the implemented memory (addi x0,x0,0).
  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] addr;
    logic              err;
  } imem_resp_t;

  // Byte address to the address of the word containing it.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] byte_addr);
    return byte_addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Response buffer for imem_responder: DEPTH entries of imem_resp_t with
// wrap-around pointers; head reads zero while empty.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  imem_resp_t push_data,
  input  logic       pop,
  output imem_resp_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  imem_resp_t       store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : store[rd_ptr];

  // Pointers and occupancy; flush empties the buffer in the same edge as reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with a fixed-latency, credit-limited fetch port.
// Define IMEM_RANGE_CHK_EN to flag out-of-range fetches and drop out-of-range preloads.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = DEFAULT_MEM_WORDS,
  parameter int unsigned LATENCY    = DEFAULT_LATENCY,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  input  logic        resp_ready,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] ld_idx;
  logic             rd_oob;
  logic             ld_oob;
  logic             req_fire;
  logic             resp_fire;
  logic [CNT_W-1:0] outstanding;
  imem_resp_t       rd_ent;
  imem_resp_t       head;
  imem_resp_t       push_ent;
  logic             push_v;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_bits;

  assign rd_idx = req_addr[IDX_W+1:2];
  assign ld_idx = ld_addr[IDX_W+1:2];

`ifdef IMEM_RANGE_CHK_EN
  assign rd_oob      = (req_addr[31:IDX_W+2] != '0);
  assign ld_oob      = (ld_addr[31:IDX_W+2] != '0);
  assign resp_err    = head.err;
  assign unused_bits = ^ld_addr[1:0];
`else
  // Upper address bits alias onto the implemented words.
  assign rd_oob      = 1'b0;
  assign ld_oob      = 1'b0;
  assign resp_err    = 1'b0;
  assign unused_bits = ^{ld_addr[1:0], ld_addr[31:IDX_W+2], head.err};
`endif

  // Credit: a request is only taken if a buffer slot is guaranteed for it.
  assign req_ready  = (outstanding < CNT_W'(FIFO_DEPTH)) && !flush && !rst;
  assign req_fire   = req_valid && req_ready;
  assign resp_valid = !fifo_empty;
  assign resp_fire  = resp_valid && resp_ready;
  assign resp_data  = head.data;
  assign resp_addr  = head.addr;

  // Read in the acceptance cycle sees the word before any same-cycle preload.
  always_comb begin
    rd_ent      = '0;
    rd_ent.data = rd_oob ? NOP_INST : mem[rd_idx];
    rd_ent.addr = word_align(req_addr);
    rd_ent.err  = rd_oob;
  end

  // Preload port; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (ld_en && !ld_oob) mem[ld_idx] <= ld_data;
  end

  // The FIFO push is itself the last stage, so LATENCY-1 register stages precede it.
  if (LATENCY == 1) begin : g_no_pipe
    assign push_v   = req_fire;
    assign push_ent = rd_ent;
  end else begin : g_pipe
    logic [LATENCY-2:0] stage_v;
    imem_resp_t         stage_d [LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        stage_v <= '0;
      end else begin
        stage_v[0] <= req_fire;
        for (int unsigned i = 1; i < LATENCY - 1; i++) stage_v[i] <= stage_v[i-1];
      end
    end

    always_ff @(posedge clk) begin
      stage_d[0] <= rd_ent;
      for (int unsigned i = 1; i < LATENCY - 1; i++) stage_d[i] <= stage_d[i-1];
    end

    assign push_v   = stage_v[LATENCY-2];
    assign push_ent = stage_d[LATENCY-2];
  end

  // Credits bound occupancy, so a full buffer here only coincides with a pop.
  assign fifo_push = push_v && (!fifo_full || resp_fire);

  imem_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (push_ent),
    .pop       (resp_fire),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Requests accepted but not yet consumed, counting pipeline and buffer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
